// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
//   Bundles the keyboard-side PS/2 lines and the decoded-key outputs of the
//   calculator front end.
//   ps2_clk   : raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data  : raw PS/2 data from the keyboard (asynchronous)
//   key_code  : decoded calculator key, zero-extended 0-14, held between strobes
//   key_valid : one-cycle strobe marking a new key_code
//   frame_err : one-cycle strobe on a parity or stop-bit error
//   modport master : the decoder (consumes PS/2 lines, drives key outputs)
//   modport slave  : the keyboard/consumer side (the opposite directions)
interface ps2_key_decoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] key_code;
    logic        key_valid;
    logic        frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output key_code,
        output key_valid,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  key_code,
        input  key_valid,
        input  frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receives PS/2 scan-code-set-2 frames, strips break (F0) and extended (E0)
//   prefixes and translates make codes into calculator keys:
//   0-9 digits, 10 plus, 11 minus, 12 multiply, 13 divide, 14 enter.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : ps2_key_decoder_if.master (PS/2 lines in, key_code/key_valid/frame_err out)
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    ps2_key_decoder_if.master         bus
);

    localparam int         TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] NO_KEY = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  clk_filt;
    logic                  fall;
    logic                  rx_bit;

    rx_state_t   state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        break_q, break_d;
    logic        ext_q, ext_d;
    logic [10:0] key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [3:0]  mapped;

    // Translate a make code into a calculator key; NO_KEY marks unmapped codes.
    function automatic logic [3:0] lookup(input logic [7:0] code, input logic extended);
        logic [3:0] key;
        key = NO_KEY;
        if (extended) begin
            case (code)
                8'h4A:   key = 4'd13;
                8'h5A:   key = 4'd14;
                default: key = NO_KEY;
            endcase
        end else begin
            case (code)
                8'h45, 8'h70: key = 4'd0;
                8'h16, 8'h69: key = 4'd1;
                8'h1E, 8'h72: key = 4'd2;
                8'h26, 8'h7A: key = 4'd3;
                8'h25, 8'h6B: key = 4'd4;
                8'h2E, 8'h73: key = 4'd5;
                8'h36, 8'h74: key = 4'd6;
                8'h3D, 8'h6C: key = 4'd7;
                8'h3E, 8'h75: key = 4'd8;
                8'h46, 8'h7D: key = 4'd9;
                8'h79:        key = 4'd10;
                8'h7B, 8'h4E: key = 4'd11;
                8'h7C:        key = 4'd12;
                8'h5A:        key = 4'd14;
                default:      key = NO_KEY;
            endcase
        end
        return key;
    endfunction

    // Bring both PS/2 lines into the clk domain, then debounce the clock line:
    // the filtered level only moves once FILTER_LEN consecutive samples agree,
    // so short glitches on ps2_clk never create an edge. Idle lines are high,
    // hence the all-ones reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_hist  <= '1;
            clk_filt  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
            clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            if (&clk_hist) begin
                clk_filt <= 1'b1;
            end else if (~|clk_hist) begin
                clk_filt <= 1'b0;
            end
        end
    end

    assign fall   = clk_filt & ~|clk_hist;
    assign rx_bit = data_sync[1];

    // Register all receiver/decoder state; the next values come from the
    // combinational block below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            break_q     <= 1'b0;
            ext_q       <= 1'b0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            break_q     <= break_d;
            ext_q       <= ext_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame receiver plus byte decoder. Bits are only taken on filtered
    // falling edges. When the stop bit arrives the frame is checked and, if
    // good, the byte is decoded in the same cycle so key_valid appears on the
    // very next clk edge. A stalled frame is abandoned by the timeout without
    // touching the prefix flags, unlike a bad frame which clears them.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        break_d     = break_q;
        ext_d       = ext_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        mapped      = lookup(shift_q, ext_q);

        case (state_q)
            IDLE: begin
                if (fall && !rx_bit) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = rx_bit;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = rx_bit;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if ((^{shift_q, parity_q}) && rx_bit) begin
                        if (shift_q == 8'hF0) begin
                            break_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else begin
                            if (!break_q && mapped != NO_KEY) begin
                                key_code_d  = {7'd0, mapped};
                                key_valid_d = 1'b1;
                            end
                            break_d = 1'b0;
                            ext_d   = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        break_d     = 1'b0;
                        ext_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (fall) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Self-checking bench for ps2_key_decoder. PS/2 frames are bit-banged with
//   a scaled-down PS/2 clock; a byte-level reference model built from the key
//   tables predicts every key strobe and frame error.
module tb_ps2_key_decoder;

    localparam int HALF = 20;
    localparam int TMO  = 300;

    logic clk = 1'b0;
    logic rst;

    ps2_key_decoder_if dut_if ();

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    // 100 MHz-style free-running clock for the bench.
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    int main_map[logic [7:0]];
    int ext_map[logic [7:0]];
    int exp_q[$];
    int obs_q[$];
    bit m_brk;
    bit m_ext;
    int m_last;
    int m_errs;

    int   err_cycles  = 0;
    int   long_pulses = 0;
    logic kv_prev     = 1'b0;

    logic [7:0] row_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pad_codes[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] pool[14]      = '{8'h16, 8'h45, 8'h79, 8'h7B, 8'h4E, 8'h7C, 8'h5A, 8'h4A,
                                  8'hF0, 8'hE0, 8'h70, 8'h7D, 8'h3D, 8'h00};

    // Observe outputs mid-cycle: record each new key strobe, flag strobes
    // longer than one cycle and count cycles with frame_err high.
    initial begin
        forever begin
            @(negedge clk);
            if (dut_if.key_valid === 1'b1) begin
                if (kv_prev) begin
                    long_pulses++;
                end else begin
                    obs_q.push_back(int'(dut_if.key_code));
                end
            end
            if (dut_if.frame_err === 1'b1) begin
                err_cycles++;
            end
            kv_prev = (dut_if.key_valid === 1'b1);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Byte-level reference: prefixes set flags, a bad frame clears them,
    // any other byte either is a release (dropped) or is looked up.
    task automatic modelFrame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
            m_errs++;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            if (!m_brk) begin
                if (m_ext && ext_map.exists(b)) begin
                    exp_q.push_back(ext_map[b]);
                    m_last = ext_map[b];
                end else if (!m_ext && main_map.exists(b)) begin
                    exp_q.push_back(main_map[b]);
                    m_last = main_map[b];
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // One PS/2 bit: data changes mid-high, then a full low phase. Optional
    // single-cycle glitches land in the settled part of each phase.
    task automatic driveBit(input logic v, input bit glitch);
        waitCycles(HALF / 2);
        dut_if.ps2_data = v;
        waitCycles(HALF / 2 - 5);
        if (glitch) begin
            dut_if.ps2_clk = 1'b0;
            waitCycles(1);
            dut_if.ps2_clk = 1'b1;
            waitCycles(4);
        end else begin
            waitCycles(5);
        end
        dut_if.ps2_clk = 1'b0;
        waitCycles(14);
        if (glitch) begin
            dut_if.ps2_clk = 1'b1;
            waitCycles(1);
            dut_if.ps2_clk = 1'b0;
            waitCycles(5);
        end else begin
            waitCycles(6);
        end
        dut_if.ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_parity, input int nbits, input bit glitch);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            driveBit(frame[i], glitch);
        end
        dut_if.ps2_data = 1'b1;
        waitCycles(2 * HALF);
        if (nbits == 11) begin
            modelFrame(b, !bad_parity);
        end
    endtask

    task automatic checkKeys(input string tag);
        checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput({tag, "_key"}, obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
        checkOutput({tag, "_hold"}, dut_if.key_code, m_last);
        checkOutput({tag, "_strobe_len"}, long_pulses, 0);
        checkOutput({tag, "_errs"}, err_cycles, m_errs);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            main_map[row_codes[i]] = i;
            main_map[pad_codes[i]] = i;
        end
        main_map[8'h79] = 10;
        main_map[8'h7B] = 11;
        main_map[8'h4E] = 11;
        main_map[8'h7C] = 12;
        main_map[8'h5A] = 14;
        ext_map[8'h4A]  = 13;
        ext_map[8'h5A]  = 14;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_last = 0;
        m_errs = 0;

        rst            = 1'b1;
        dut_if.ps2_clk  = 1'b1;
        dut_if.ps2_data = 1'b1;
        waitCycles(5);
        checkOutput("reset_key_code", dut_if.key_code, 0);
        checkOutput("reset_key_valid", dut_if.key_valid, 0);
        checkOutput("reset_frame_err", dut_if.frame_err, 0);
        rst = 1'b0;
        waitCycles(20);

        $display("[TB] make then break of 16");
        applyStimulus(8'h16, 1'b0, 11, 1'b0);
        applyStimulus(8'hF0, 1'b0, 11, 1'b0);
        applyStimulus(8'h16, 1'b0, 11, 1'b0);
        checkOutput("make_break_code", dut_if.key_code, 1);
        checkKeys("make_break");

        $display("[TB] operator keys");
        applyStimulus(8'h79, 1'b0, 11, 1'b0);
        applyStimulus(8'h7B, 1'b0, 11, 1'b0);
        applyStimulus(8'h7C, 1'b0, 11, 1'b0);
        applyStimulus(8'h5A, 1'b0, 11, 1'b0);
        checkKeys("operators");

        $display("[TB] extended codes");
        applyStimulus(8'hE0, 1'b0, 11, 1'b0);
        applyStimulus(8'h4A, 1'b0, 11, 1'b0);
        applyStimulus(8'hE0, 1'b0, 11, 1'b0);
        applyStimulus(8'hF0, 1'b0, 11, 1'b0);
        applyStimulus(8'h4A, 1'b0, 11, 1'b0);
        applyStimulus(8'hE0, 1'b0, 11, 1'b0);
        applyStimulus(8'h70, 1'b0, 11, 1'b0);
        checkOutput("divide_code", dut_if.key_code, 13);
        checkKeys("extended");

        $display("[TB] parity error then clean frame");
        applyStimulus(8'h45, 1'b1, 11, 1'b0);
        checkOutput("parity_err_pulse", err_cycles, 1);
        applyStimulus(8'h3E, 1'b0, 11, 1'b0);
        checkOutput("after_err_code", dut_if.key_code, 8);
        checkKeys("after_err");

        $display("[TB] stalled partial frame");
        applyStimulus(8'h16, 1'b0, 5, 1'b0);
        waitCycles(TMO + 100);
        applyStimulus(8'h46, 1'b0, 11, 1'b0);
        checkOutput("timeout_code", dut_if.key_code, 9);
        checkKeys("timeout");

        $display("[TB] reset mid-frame");
        applyStimulus(8'h25, 1'b0, 4, 1'b0);
        rst = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_last = 0;
        waitCycles(1);
        checkOutput("midreset_key_code", dut_if.key_code, 0);
        checkOutput("midreset_key_valid", dut_if.key_valid, 0);
        checkOutput("midreset_frame_err", dut_if.frame_err, 0);
        waitCycles(10);
        applyStimulus(8'h1E, 1'b0, 11, 1'b0);
        checkKeys("after_reset");

        $display("[TB] glitchy ps2_clk");
        applyStimulus(8'h26, 1'b0, 11, 1'b1);
        checkOutput("glitch_code", dut_if.key_code, 3);
        checkKeys("glitch");

        $display("[TB] randomized frames");
        for (int g = 0; g < 4; g++) begin
            for (int n = 0; n < 6; n++) begin
                logic [7:0] b;
                bit         bad;
                if ($urandom_range(0, 4) == 0) begin
                    b = 8'($urandom_range(0, 255));
                end else begin
                    b = pool[$urandom_range(0, 13)];
                end
                bad = ($urandom_range(0, 7) == 0);
                applyStimulus(b, bad, 11, $urandom_range(0, 3) == 0);
            end
            checkKeys("random");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Front end of the calculator datapath: receives PS/2 keyboard frames (scan code set 2), strips break and extended prefixes, and translates make codes into calculator key codes 0-14.
- Emits each key as a one-cycle strobe plus code, which drive the operation stage's sel and data_in inputs directly.
- Key code map: 0-9 digits, 10 plus, 11 minus, 12 multiply, 13 divide, 14 enter.

Parameters:
- FILTER_LEN, 8, number of consecutive equal synchronized ps2_clk samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 100000, idle clk cycles inside a frame before the receiver aborts to IDLE (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock from the keyboard; asynchronous.
- ps2_data  in  1  raw PS/2 data from the keyboard; asynchronous.
- key_code  out  11  decoded key, zero-extended 0-14; held until the next key_valid.
- key_valid  out  1  one-cycle strobe: key_code is new.
- frame_err  out  1  one-cycle strobe on a parity or stop-bit error.

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, from any state including mid-frame: key_code=0, key_valid=0, frame_err=0, receiver in IDLE, bit counter 0, shift register 0, break_pending=0, ext_pending=0, filter history all 1s, timeout counter 0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock level changes only when the last FILTER_LEN synchronized samples are all equal.
  - Falling edge = filtered level goes 1->0; all sampling of ps2_data happens on this edge.
- Receiver FSM (11-bit frame: start, 8 data LSB first, odd parity, stop):
  - IDLE: on a falling edge, if data=0 go to DATA with count=0; if data=1 stay in IDLE (spurious start, no error).
  - DATA: shift data into bit[count]; after 8 bits go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP: check the frame.
    - Valid frame requires ^{byte,parity}=1 and stop=1; the byte is handed to the decoder; return to IDLE.
    - Otherwise pulse frame_err for 1 cycle, clear break_pending and ext_pending, and return to IDLE.
  - Timeout: in any non-IDLE state, the counter resets on each falling edge. Reaching TIMEOUT_CYCLES returns the FSM to IDLE silently; no frame_err, prefix flags unchanged.
- Decoder, acting on each valid byte:
  - F0: set break_pending.
  - E0: set ext_pending.
  - Any other byte while break_pending=1: discard it (release), clear both flags.
  - Otherwise: look the byte up using ext_pending; if mapped, emit it; clear both flags.
- Map, non-extended:
  - Digits 0-9, main row: 45,16,1E,26,25,2E,36,3D,3E,46.
  - Digits 0-9, keypad: 70,69,72,7A,6B,73,74,6C,75,7D.
  - Plus: 79 -> 10.
  - Minus: 7B and 4E -> 11.
  - Multiply: 7C -> 12.
  - Enter: 5A -> 14.
- Map, extended: E0 4A -> 13, E0 5A -> 14; all other E0 codes are dropped.
- Unmapped codes are dropped silently; no error is flagged.
- Latency and hold:
  - key_valid and key_code update on the clk edge after the stop-bit falling edge is processed.
  - key_valid is high for exactly 1 cycle; key_code holds its value afterwards.
- Typematic repeats: repeated make codes each produce a key_valid. Downstream treats them as separate keystrokes.
- Back-to-back frames: the minimum spacing between key_valid pulses is one full frame, so no buffering is required.

Test Plan:
- Bench setup: PS/2 clock period 40 us (2000 clk cycles), data changes at mid-high.
- Make 16, then break F0 16 -> one key_valid with key_code=1; no pulse for the break sequence.
- Keypad 79, then 7B, 7C, 5A -> key_codes 10, 11, 12, 14 in order; key_valid high exactly 1 cycle each.
- E0 4A, then E0 F0 4A -> one key_valid with key_code=13. Also send E0 70 -> nothing emitted.
- Frame for 45 with even parity -> frame_err pulses once, no key_valid. Next clean frame 3E -> key_code=8.
- Send 5 bits of a frame, stall 3 ms, then a full frame 46 -> no error, one key_valid with key_code=9.
- Assert rst mid-frame after 4 bits -> all outputs 0; the following full frame 1E -> key_code=2.
- 1-cycle glitch pulses on ps2_clk between edges -> ignored; decoded byte is unchanged.
